// File: rtl/inst_decoder.sv
// inst_decoder: multi-word instruction decoder for the MACPU core.
// It takes opcode and argument words over a valid/ready fetch handshake.
// It issues one decoded micro-op over a valid/ready issue handshake.
//
// State table:
//   S_OP    | waiting for an opcode word
//   S_ARG   | collecting argument words for the current opcode
//   S_ISSUE | micro-op presented, waiting for i_uop_ready
//
// Ports:
//   clk, rst (async, active-low)
//   i_fetch_data/i_fetch_valid/o_fetch_ready : fetch handshake
//   o_pc_inc                                 : fetch handshake strobe
//   i_lock, i_flush                          : global stall / abort
//   o_uop_valid/i_uop_ready                  : issue handshake
//   o_uop_kind, o_uop_alu_op, o_uop_reg_a, o_uop_reg_b, o_uop_imm, o_uop_addr
//   o_illegal, o_busy                        : status
module inst_decoder #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int REG_SEL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    i_fetch_data,
  input  logic                 i_fetch_valid,
  output logic                 o_fetch_ready,
  output logic                 o_pc_inc,
  input  logic                 i_lock,
  input  logic                 i_flush,
  output logic                 o_uop_valid,
  input  logic                 i_uop_ready,
  output logic [2:0]           o_uop_kind,
  output logic [7:0]           o_uop_alu_op,
  output logic [REG_SEL_W-1:0] o_uop_reg_a,
  output logic [REG_SEL_W-1:0] o_uop_reg_b,
  output logic [DATA_W-1:0]    o_uop_imm,
  output logic [ADDR_W-1:0]    o_uop_addr,
  output logic                 o_illegal,
  output logic                 o_busy
);

  // Shared instruction encodings, matched against word[15:0]
  localparam logic [15:0] OP_NOP    = 16'h0000;
  localparam logic [15:0] OP_LOAD   = 16'h0010;
  localparam logic [15:0] OP_MOV_RR = 16'h0020;
  localparam logic [15:0] OP_ADD    = 16'h0021;
  localparam logic [15:0] OP_MOV_RA = 16'h0030;
  localparam logic [15:0] OP_JMP    = 16'h0040;

  localparam logic [2:0] K_NONE  = 3'd0;
  localparam logic [2:0] K_LDI   = 3'd1;
  localparam logic [2:0] K_ALU   = 3'd2;
  localparam logic [2:0] K_STORE = 3'd3;
  localparam logic [2:0] K_JUMP  = 3'd4;

  typedef enum logic [1:0] {S_OP, S_ARG, S_ISSUE} state_t;

  state_t               state_q, state_d;
  logic                 cnt_q, cnt_d;
  logic [2:0]           kind_q, kind_d;
  logic [7:0]           alu_q, alu_d;
  logic [REG_SEL_W-1:0] reg_a_q, reg_a_d;
  logic [REG_SEL_W-1:0] reg_b_q, reg_b_d;
  logic [DATA_W-1:0]    imm_q, imm_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 illegal_q, illegal_d;

  logic                 upper_nz;
  logic                 fire;
  logic                 op_legal;
  logic                 op_nop;
  logic [2:0]           op_kind;
  logic [7:0]           op_alu;
  logic                 last_arg;

  // Words wider than 16 bits must have a clear upper part to be legal
  if (DATA_W > 16) begin : g_upper
    assign upper_nz = |i_fetch_data[DATA_W-1:16];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  assign o_fetch_ready = !i_lock && !i_flush && (state_q != S_ISSUE);
  assign fire          = i_fetch_valid && o_fetch_ready;
  assign o_pc_inc      = fire;
  assign o_uop_valid   = (state_q == S_ISSUE);
  assign o_busy        = (state_q != S_OP);
  assign o_uop_kind    = o_uop_valid ? kind_q : K_NONE;
  assign o_uop_alu_op  = alu_q;
  assign o_uop_reg_a   = reg_a_q;
  assign o_uop_reg_b   = reg_b_q;
  assign o_uop_imm     = imm_q;
  assign o_uop_addr    = addr_q;
  assign o_illegal     = illegal_q;

  // JUMP takes one argument, everything else that reaches S_ARG takes two
  assign last_arg = (kind_q == K_JUMP) || cnt_q;

  always_comb begin
    op_legal = !upper_nz;
    op_nop   = 1'b0;
    op_kind  = K_NONE;
    op_alu   = 8'h00;
    case (i_fetch_data[15:0])
      OP_NOP:    op_nop  = 1'b1;
      OP_LOAD:   op_kind = K_LDI;
      OP_ADD:    op_kind = K_ALU;
      OP_MOV_RR: begin
        op_kind = K_ALU;
        op_alu  = 8'hFF;
      end
      OP_MOV_RA: op_kind = K_STORE;
      OP_JMP:    op_kind = K_JUMP;
      default:   op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    alu_d     = alu_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    imm_d     = imm_q;
    addr_d    = addr_q;
    illegal_d = 1'b0;
    if (i_flush) begin
      state_d = S_OP;
      cnt_d   = 1'b0;
      kind_d  = K_NONE;
    end else if (!i_lock) begin
      case (state_q)
        S_OP: begin
          if (fire) begin
            if (!op_legal) begin
              illegal_d = 1'b1;
            end else if (!op_nop) begin
              state_d = S_ARG;
              cnt_d   = 1'b0;
              kind_d  = op_kind;
              alu_d   = op_alu;
              reg_a_d = '0;
              reg_b_d = '0;
              imm_d   = '0;
              addr_d  = '0;
            end
          end
        end
        S_ARG: begin
          if (fire) begin
            case (kind_q)
              K_LDI:
                if (!cnt_q) imm_d = i_fetch_data;
                else        reg_a_d = i_fetch_data[REG_SEL_W-1:0];
              K_ALU:
                if (!cnt_q) reg_a_d = i_fetch_data[REG_SEL_W-1:0];
                else        reg_b_d = i_fetch_data[REG_SEL_W-1:0];
              K_STORE:
                if (!cnt_q) reg_a_d = i_fetch_data[REG_SEL_W-1:0];
                else        addr_d  = i_fetch_data[ADDR_W-1:0];
              default: addr_d = i_fetch_data[ADDR_W-1:0];
            endcase
            if (last_arg) begin
              state_d = S_ISSUE;
              cnt_d   = 1'b0;
            end else begin
              cnt_d = 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (i_uop_ready) begin
            state_d = S_OP;
            kind_d  = K_NONE;
          end
        end
        default: state_d = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_OP;
      cnt_q     <= 1'b0;
      kind_q    <= K_NONE;
      alu_q     <= 8'h00;
      reg_a_q   <= '0;
      reg_b_q   <= '0;
      imm_q     <= '0;
      addr_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      alu_q     <= alu_d;
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      imm_q     <= imm_d;
      addr_q    <= addr_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
